// File: rtl/lcd_panel_timing_gen.sv
// lcd_panel_timing_gen
// Generates the pixel clock, syncs and blanking for the 400x96 RGB555 panel,
// prefetches one pixel per slot from a one-cycle-latency frame buffer and
// holds RGB stable across the falling edge of nClock, where the panel samples.
// All outputs are registered and describe the counter position reached at
// the same Clock edge, so the first enabled Clock is frame start.

module lcd_panel_timing_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_SYNC   = 1,
   parameter int H_BACK   = 106,
   parameter int H_ACTIVE = 400,
   parameter int H_FRONT  = 3,
   parameter int V_SYNC   = 1,
   parameter int V_BACK   = 2,
   parameter int V_ACTIVE = 96,
   parameter int V_FRONT  = 5,
   parameter int ADDR_W   = 16
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              Enable,
   output logic              nClock,
   output logic              HS,
   output logic              VS,
   output logic [14:0]       RGB,
   output logic              RdEn,
   output logic [ADDR_W-1:0] RdAddr,
   input  logic [14:0]       RdData,
   output logic              FrameStart,
   output logic              VBlank
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int PW      = $clog2(CLK_DIV + 1);
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);

   localparam logic [PW-1:0] PH_ONE   = PW'(1);
   localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV / 2);
   localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_ONE    = HW'(1);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_C = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_LO = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0] H_ACT_HI = HW'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [VW-1:0] V_ONE    = VW'(1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_C = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_LO = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0] V_ACT_HI = VW'(V_SYNC + V_BACK + V_ACTIVE);

   // Current position; running is low for the first enabled Clock so that
   // Clock lands on phase 0 of hCnt=0, vCnt=0 instead of advancing past it.
   logic              running;
   logic [PW-1:0]     phase;
   logic [HW-1:0]     hCnt;
   logic [VW-1:0]     vCnt;
   logic [14:0]       hold;
   logic [ADDR_W-1:0] pixCnt;

   // Position after this Clock and everything decoded from it.
   logic [PW-1:0]     nPhase;
   logic [HW-1:0]     nH;
   logic [HW-1:0]     nHNext;
   logic [VW-1:0]     nV;
   logic              lineActive;
   logic              pixActive;
   logic              prefetch;
   logic              frameTop;
   logic [ADDR_W-1:0] pixBase;
   logic [14:0]       pixSrc;

   // Next position with simultaneous phase/line/frame wraps, plus decodes.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      nPhase = '0;
      nH     = '0;
      nV     = '0;
      if (running) begin
         nPhase = (phase == PH_LAST) ? '0 : phase + PH_ONE;
         nH     = hCnt;
         nV     = vCnt;
         if (phase == PH_LAST) begin
            nH = (hCnt == H_LAST) ? '0 : hCnt + H_ONE;
            if (hCnt == H_LAST) begin
               nV = (vCnt == V_LAST) ? '0 : vCnt + V_ONE;
            end
         end
      end
      nHNext     = nH + H_ONE;
      lineActive = (nV >= V_ACT_LO) && (nV < V_ACT_HI);
      pixActive  = lineActive && (nH >= H_ACT_LO) && (nH < H_ACT_HI);
      // The slot before an active pixel fetches it; the front porch never does.
      prefetch   = (nPhase == '0) && lineActive && (nHNext >= H_ACT_LO) && (nHNext < H_ACT_HI);
      frameTop   = (nPhase == '0) && (nH == '0) && (nV == '0);
      // Pixels are read in raster order, so the address is a running count
      // restarted at frame top rather than y*H_ACTIVE+x.
      pixBase    = frameTop ? '0 : pixCnt;
      // With CLK_DIV=2 the RAM data arrives on the same edge RGB loads, so bypass.
      pixSrc     = (phase == PH_ONE) ? RdData : hold;
   end

   // Counters, prefetch state and registered panel outputs.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         running    <= 1'b0;
         phase      <= '0;
         hCnt       <= '0;
         vCnt       <= '0;
         hold       <= '0;
         pixCnt     <= '0;
         nClock     <= 1'b1;
         HS         <= 1'b1;
         VS         <= 1'b1;
         RGB        <= '0;
         RdEn       <= 1'b0;
         RdAddr     <= '0;
         FrameStart <= 1'b0;
         VBlank     <= 1'b1;
      end else if (!Enable) begin
         running    <= 1'b0;
         phase      <= '0;
         hCnt       <= '0;
         vCnt       <= '0;
         hold       <= '0;
         pixCnt     <= '0;
         nClock     <= 1'b1;
         HS         <= 1'b1;
         VS         <= 1'b1;
         RGB        <= '0;
         RdEn       <= 1'b0;
         RdAddr     <= '0;
         FrameStart <= 1'b0;
         VBlank     <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register here sees pre-edge values of the others.
         running    <= 1'b1;
         phase      <= nPhase;
         hCnt       <= nH;
         vCnt       <= nV;
         nClock     <= (nPhase < PH_HALF);
         HS         <= (nH >= H_SYNC_C);
         VS         <= (nV >= V_SYNC_C);
         FrameStart <= frameTop;
         VBlank     <= !lineActive;
         RdEn       <= prefetch;
         if (running && (phase == PH_ONE)) begin
            hold <= RdData;
         end
         if (prefetch) begin
            RdAddr <= pixBase;
            pixCnt <= pixBase + ADDR_W'(1);
         end else begin
            pixCnt <= pixBase;
         end
         if (nPhase == '0) begin
            RGB <= pixActive ? pixSrc : '0;
         end
      end
   end

endmodule

// File: tb/tb_lcd_panel_timing_gen.sv
// Bench for lcd_panel_timing_gen: a tiny panel (CLK_DIV=2, 4x2 active,
// all syncs/porches 1) and the default 400x96 panel run side by side under
// random Enable drops and asynchronous resets. Expected outputs come from
// the elapsed-Clock count since frame start, decomposed into phase, slot,
// column and line with plain division.

module tb_lcd_panel_timing_gen;

   typedef struct packed {
      int clkDiv;
      int hSync;
      int hBack;
      int hActive;
      int hFront;
      int vSync;
      int vBack;
      int vActive;
      int vFront;
   } cfg_t;

   typedef struct packed {
      logic        idle;
      logic        nClock;
      logic        hs;
      logic        vs;
      logic        frameStart;
      logic        vBlank;
      logic        rdEn;
      logic [14:0] rgb;
      logic [15:0] rdAddr;
   } exp_t;

   localparam cfg_t CFG_A = '{2, 1, 1, 4, 1, 1, 1, 2, 1};
   localparam cfg_t CFG_B = '{4, 1, 106, 400, 3, 1, 2, 96, 5};

   logic        Clock;
   logic        nReset;
   logic        enA, enB;
   logic        nClockA, hsA, vsA, fsA, vbA, rdEnA;
   logic        nClockB, hsB, vsB, fsB, vbB, rdEnB;
   logic [14:0] rgbA, rdDataA, rgbB, rdDataB;
   logic [15:0] rdAddrA, rdAddrB;

   logic [14:0] mem [0:65535];

   int tA = -1;
   int tB = -1;
   int nChecks = 0;
   int nPassed = 0;

   lcd_panel_timing_gen #(
      .CLK_DIV(CFG_A.clkDiv), .H_SYNC(CFG_A.hSync), .H_BACK(CFG_A.hBack),
      .H_ACTIVE(CFG_A.hActive), .H_FRONT(CFG_A.hFront), .V_SYNC(CFG_A.vSync),
      .V_BACK(CFG_A.vBack), .V_ACTIVE(CFG_A.vActive), .V_FRONT(CFG_A.vFront),
      .ADDR_W(16)
   ) dutA (
      .Clock(Clock), .nReset(nReset), .Enable(enA), .nClock(nClockA),
      .HS(hsA), .VS(vsA), .RGB(rgbA), .RdEn(rdEnA), .RdAddr(rdAddrA),
      .RdData(rdDataA), .FrameStart(fsA), .VBlank(vbA)
   );

   lcd_panel_timing_gen #(
      .CLK_DIV(CFG_B.clkDiv), .H_SYNC(CFG_B.hSync), .H_BACK(CFG_B.hBack),
      .H_ACTIVE(CFG_B.hActive), .H_FRONT(CFG_B.hFront), .V_SYNC(CFG_B.vSync),
      .V_BACK(CFG_B.vBack), .V_ACTIVE(CFG_B.vActive), .V_FRONT(CFG_B.vFront),
      .ADDR_W(16)
   ) dutB (
      .Clock(Clock), .nReset(nReset), .Enable(enB), .nClock(nClockB),
      .HS(hsB), .VS(vsB), .RGB(rgbB), .RdEn(rdEnB), .RdAddr(rdAddrB),
      .RdData(rdDataB), .FrameStart(fsB), .VBlank(vbB)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Synchronous-read frame buffers, one Clock of latency.
   always @(posedge Clock) begin
      if (rdEnA) rdDataA <= mem[rdAddrA];
      if (rdEnB) rdDataB <= mem[rdAddrB];
   end

   task automatic check(input string tag, input int obs, input int exp);
      nChecks++;
      if (obs == exp) nPassed++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Expected outputs t Clocks after frame start (t < 0: idle).
   function automatic exp_t model(input cfg_t c, input int t);
      exp_t e;
      int   p, slot, h, v, hA, vA, hT, vT;
      logic lineAct;
      e = '0;
      e.idle = 1'b1; e.nClock = 1'b1; e.hs = 1'b1; e.vs = 1'b1; e.vBlank = 1'b1;
      if (t < 0) return e;
      hA      = c.hSync + c.hBack;
      vA      = c.vSync + c.vBack;
      hT      = hA + c.hActive + c.hFront;
      vT      = vA + c.vActive + c.vFront;
      p       = t % c.clkDiv;
      slot    = t / c.clkDiv;
      h       = slot % hT;
      v       = (slot / hT) % vT;
      lineAct = (v >= vA) && (v < vA + c.vActive);
      e.idle       = 1'b0;
      e.nClock     = (p < c.clkDiv / 2);
      e.hs         = (h >= c.hSync);
      e.vs         = (v >= c.vSync);
      e.frameStart = ((t % (c.clkDiv * hT * vT)) == 0);
      e.vBlank     = !lineAct;
      e.rdEn       = (p == 0) && lineAct && (h + 1 >= hA) && (h + 1 < hA + c.hActive);
      if (e.rdEn) e.rdAddr = 16'((v - vA) * c.hActive + (h + 1 - hA));
      if (lineAct && (h >= hA) && (h < hA + c.hActive))
         e.rgb = mem[(v - vA) * c.hActive + (h - hA)];
      return e;
   endfunction

   task automatic checkDut(input string n, input exp_t e, input logic nClk,
                           input logic hs, input logic vs, input logic fs,
                           input logic vb, input logic re, input logic [14:0] rgb,
                           input logic [15:0] addr);
      check({n, ".nClock"}, int'(nClk), int'(e.nClock));
      check({n, ".HS"}, int'(hs), int'(e.hs));
      check({n, ".VS"}, int'(vs), int'(e.vs));
      check({n, ".FrameStart"}, int'(fs), int'(e.frameStart));
      check({n, ".VBlank"}, int'(vb), int'(e.vBlank));
      check({n, ".RdEn"}, int'(re), int'(e.rdEn));
      check({n, ".RGB"}, int'(rgb), int'(e.rgb));
      if (e.idle || e.rdEn) check({n, ".RdAddr"}, int'(addr), int'(e.rdAddr));
   endtask

   task automatic checkBoth(input string n);
      checkDut({n, "A"}, model(CFG_A, tA), nClockA, hsA, vsA, fsA, vbA, rdEnA, rgbA, rdAddrA);
      checkDut({n, "B"}, model(CFG_B, tB), nClockB, hsB, vsB, fsB, vbB, rdEnB, rgbB, rdAddrB);
   endtask

   // One Clock: advance the models with the inputs seen at the edge, compare mid-cycle.
   task automatic tick();
      @(posedge Clock);
      tA = (!nReset || !enA) ? -1 : tA + 1;
      tB = (!nReset || !enB) ? -1 : tB + 1;
      @(negedge Clock);
      checkBoth("");
   endtask

   // Assert reset between edges and check outputs drop without waiting for Clock.
   task automatic asyncResetPulse();
      #3 nReset = 1'b0;
      #1;
      tA = -1;
      tB = -1;
      checkBoth("async");
      tick();
      nReset = 1'b1;
   endtask

   int hsLow, firstRd, firstAddr, rdCount, lastAddr;

   initial begin
      nReset = 1'b0;
      enA    = 1'b0;
      enB    = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 15'($urandom);
      repeat (3) tick();
      nReset = 1'b1;
      enA    = 1'b1;
      enB    = 1'b1;

      // Default panel runs uninterrupted into its first active lines.
      hsLow     = 0;
      firstRd   = -1;
      firstAddr = -1;
      for (int i = 0; i < 9000; i++) begin
         tick();
         if (tB >= 0 && tB < 2040 && !hsB) hsLow++;
         if (rdEnB && firstRd < 0) begin
            firstRd   = tB;
            firstAddr = int'(rdAddrB);
         end
         if ($urandom_range(0, 99) < 3) enA = !enA;
      end
      check("B.hsLowClocksLine0", hsLow, 4);
      check("B.firstRdEnClock", firstRd, 6544);
      check("B.firstRdAddr", firstAddr, 0);

      // Mid-frame asynchronous reset, then restart at frame start.
      enA = 1'b1;
      tick();
      asyncResetPulse();
      tick();
      check("A.frameStartAfterReset", int'(fsA), 1);
      check("B.frameStartAfterReset", int'(fsB), 1);

      // One full tiny frame: eight strobes, addresses ending at 7.
      rdCount  = 0;
      lastAddr = -1;
      for (int i = 0; i < 70; i++) begin
         if (rdEnA) begin
            rdCount++;
            lastAddr = int'(rdAddrA);
         end
         tick();
      end
      check("A.rdEnPerFrame", rdCount, 8);
      check("A.lastRdAddr", lastAddr, 7);

      // Enable low for 10 Clocks mid-line.
      repeat (5) tick();
      enA = 1'b0;
      enB = 1'b0;
      repeat (10) tick();
      enA = 1'b1;
      enB = 1'b1;
      tick();
      check("A.frameStartReenable", int'(fsA), 1);
      check("B.frameStartReenable", int'(fsB), 1);
      check("A.hsLowReenable", int'(hsA), 0);
      check("B.vsLowReenable", int'(vsB), 0);

      // Random Enable drops and asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) enA = !enA;
         if ($urandom_range(0, 29) == 0) enB = !enB;
         if ($urandom_range(0, 299) == 0) asyncResetPulse();
         else tick();
      end

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
